prll_bs_rr_rbtr: RTL and testbench
==================================

PRLL_BS_RR_RBTR -- requirements
Module: prll_bs_rr_rbtr

Interface
REQ-001 SHALL have parameter drvrs, default 6: number of driver channels, 2..16.
REQ-002 SHALL have parameter bits, default 32: word width, at least 9.
REQ-003 SHALL have parameter id_w, default 8: destination-ID field width, taken as bits D[bits-1 -: id_w].
REQ-004 SHALL have parameter broadcast, default {id_w{1'b1}}: destination ID meaning "all drivers except source".
REQ-005 SHALL have port clk  in  1: single clock, rising edge.
REQ-006 SHALL have port reset  in  1: asynchronous, active-low reset.
REQ-007 SHALL have port pndng  in  drvrs: bit i high means driver i has a word pending (FWFT, data valid on D_pop).
REQ-008 SHALL have port D_pop  in  drvrs*bits: flat vector; slice i is driver i head word.
REQ-009 SHALL have port pop  out  drvrs: one-cycle pop strobe to driver i.
REQ-010 SHALL have port push  out  drvrs: one-cycle push strobe to driver i.
REQ-011 SHALL have port D_push  out  drvrs*bits: flat vector; every slice carries the delivered word.
REQ-012 SHALL have port busy  out  1: high whenever the FSM is not IDLE.
REQ-013 SHALL have port drop_cnt  out  16: count of words with an invalid destination.

Function
REQ-014 SHALL implement FSM states IDLE, POP, DELIVER; outputs are decoded from registered state/grant only.
REQ-015 IDLE: if any pndng bit is high, SHALL register gnt = first pending index searching from rr_ptr upward with wrap, then go to POP; otherwise stay in IDLE.
REQ-016 POP: SHALL assert pop[gnt] for exactly this cycle, capture D_pop slice gnt into data_reg at the cycle end, and go to DELIVER.
REQ-017 DELIVER: SHALL drive push per REQ-018..020 for exactly one cycle, set rr_ptr = (gnt+1) mod drvrs, and return to IDLE.
REQ-018 When dest == broadcast, SHALL push to every driver except gnt.
REQ-019 When dest < drvrs, SHALL push only to driver dest; dest == gnt is legal (loopback).
REQ-020 Any other dest SHALL produce no push and SHALL increment drop_cnt, saturating at 16'hFFFF.
REQ-021 D_push slices SHALL equal data_reg at all times; the value is only meaningful while push is asserted.
REQ-022 Throughput SHALL be one word per 3 cycles; the IDLE→POP decision is made the cycle pndng is seen high.
REQ-023 Changes to pndng during POP/DELIVER SHALL not alter gnt or the transfer in flight.
REQ-024 At most one pop bit SHALL be high in any cycle; pop and push SHALL never be high in the same cycle.
REQ-025 Driver gnt SHALL be lowest priority in the next arbitration, giving a starvation bound of drvrs transfers.

Reset
REQ-026 reset low SHALL asynchronously force state=IDLE, rr_ptr=0, gnt=0, data_reg=0, drop_cnt=0, pop=0, push=0, busy=0.
REQ-027 Reset during POP or DELIVER SHALL abort the transfer with no push; a word already popped is lost.
REQ-028 After reset release, the first arbitration SHALL start from driver 0.

Structure
REQ-029 Package prll_bs_pkg SHALL hold the state enum (IDLE, POP, DELIVER) and the default ID-width and broadcast constants.
REQ-030 The round-robin search SHALL live in sub-module rr_pick (inputs: req vector and ptr; outputs: idx and valid), which is purely combinational.

Verification
REQ-031 Scenario: pndng=000001, D_pop0=0x03_00ABCD → pop[0] in cycle 1, push=001000 in cycle 2, D_push slices = 0x0300ABCD.
REQ-032 Scenario: all six pending continuously → grants in order 0,1,2,3,4,5,0, each spaced 3 cycles apart.
REQ-033 Scenario: driver 2 sends dest 0xFF → push=111011 for one cycle.
REQ-034 Scenario: dest 0x09 with drvrs=6 → no push and drop_cnt=1; a 65536th drop leaves drop_cnt at 0xFFFF.
REQ-035 Scenario: reset asserted during DELIVER → push stays 0, busy=0 immediately, and the next grant comes from driver 0.
REQ-036 Scenario: driver 4 sends dest 4 → push=010000 (loopback); a random pndng toggle check shows pop stays one-hot and no overlap occurs.

Source files
------------

// File: rtl/prll_bs_pkg.sv
// Shared types and constants for the parallel-bus round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the transfer FSM encoding, the default destination-ID geometry
// and a small pointer-wrap helper used by the top level.
package prll_bs_pkg;

    // Transfer FSM: one arbitration cycle, one pop cycle, one delivery cycle.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        POP     = 2'd1,
        DELIVER = 2'd2
    } state_t;

    // Default destination-ID width and the all-ones broadcast ID.
    localparam int                    DEF_ID_W      = 8;
    localparam logic [DEF_ID_W-1:0]   DEF_BROADCAST = {DEF_ID_W{1'b1}};

    // Next round-robin pointer: the slot just after g, wrapping at n.
    function automatic int rr_next(input int g, input int n);
        return (g >= n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/prll_bs_rr_rbtr_rr_pick.sv
// Round-robin search: first set request at or above ptr, wrapping at n.
// Latency: purely combinational, zero cycles.
// Backpressure: none; valid is low when no request is set.
//
// Ports: req (n request bits), ptr (start index, < n),
//        idx (chosen index), valid (any request set).
module rr_pick #(
    parameter int n = 6,
    parameter int w = 3
) (
    input  logic [n-1:0] req,
    input  logic [w-1:0] ptr,
    output logic [w-1:0] idx,
    output logic         valid
);

    always_comb begin : pick_search
        int c;
        idx   = '0;
        valid = 1'b0;
        c     = 0;
        for (int k = 0; k < n; k++) begin
            // ptr is always below n, so a single subtraction wraps the slot.
            c = int'(ptr) + k;
            if (c >= n) begin
                c = c - n;
            end
            if (!valid && req[c]) begin
                valid = 1'b1;
                idx   = w'(c);
            end
        end
    end

endmodule

// File: rtl/prll_bs_rr_rbtr.sv
// Round-robin arbiter moving one word per transfer from a pending driver
// FIFO head to one / all-but-source / no drivers, by destination ID.
// Latency: arbitrate, pop, deliver -- one word every 3 cycles.
// Backpressure: none downstream; pop only drains a FIFO that flags pndng.
//
// Ports:
//   clk, reset       clock (rising edge) and async active-low reset
//   pndng  [drvrs]   driver i has a head word on its D_pop slice (FWFT)
//   D_pop  [drvrs*bits] flat head words, slice i belongs to driver i
//   pop    [drvrs]   one-cycle pop strobe to the granted driver
//   push   [drvrs]   one-cycle push strobe(s) for the delivered word
//   D_push [drvrs*bits] delivered word replicated on every slice
//   busy             FSM is not idle
//   drop_cnt [16]    saturating count of words with an invalid destination
module prll_bs_rr_rbtr
    import prll_bs_pkg::*;
#(
    parameter int               drvrs     = 6,
    parameter int               bits      = 32,
    parameter int               id_w      = DEF_ID_W,
    parameter logic [id_w-1:0]  broadcast = {id_w{1'b1}}
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [drvrs-1:0]        pndng,
    input  logic [drvrs*bits-1:0]   D_pop,
    output logic [drvrs-1:0]        pop,
    output logic [drvrs-1:0]        push,
    output logic [drvrs*bits-1:0]   D_push,
    output logic                    busy,
    output logic [15:0]             drop_cnt
);

    localparam int GW = (drvrs > 1) ? $clog2(drvrs) : 1;

    state_t             state_q;
    logic [GW-1:0]      gnt_q;
    logic [GW-1:0]      rr_ptr_q;
    logic [bits-1:0]    data_reg;
    logic [15:0]        drop_cnt_q;

    logic [GW-1:0]      pick_idx;
    logic               pick_vld;

    logic [id_w-1:0]    dest;
    logic               dest_is_bcast;
    logic               dest_is_uni;
    logic               dest_is_drop;

    rr_pick #(
        .n (drvrs),
        .w (GW)
    ) u_rr_pick (
        .req   (pndng),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    // Destination ID lives in the top id_w bits of the captured word.
    // Broadcast is tested first so it wins even when it is numerically < drvrs.
    assign dest          = data_reg[bits-1 -: id_w];
    assign dest_is_bcast = (dest == broadcast);
    assign dest_is_uni   = !dest_is_bcast && (int'(dest) < drvrs);
    assign dest_is_drop  = !dest_is_bcast && !dest_is_uni;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            rr_ptr_q   <= '0;
            data_reg   <= '0;
            drop_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_q   <= pick_idx;
                        state_q <= POP;
                    end
                end
                POP: begin
                    // gnt_q is frozen from here on, so pndng changes cannot
                    // redirect the word already being popped.
                    data_reg <= D_pop[int'(gnt_q)*bits +: bits];
                    state_q  <= DELIVER;
                end
                DELIVER: begin
                    // Winner becomes lowest priority for the next search.
                    rr_ptr_q <= GW'(rr_next(int'(gnt_q), drvrs));
                    if (dest_is_drop && (drop_cnt_q != 16'hFFFF)) begin
                        drop_cnt_q <= drop_cnt_q + 16'd1;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Strobes depend on registered state only; pop and push live in
    // different states, so they can never overlap.
    always_comb begin
        pop  = '0;
        push = '0;
        for (int i = 0; i < drvrs; i++) begin
            if ((state_q == POP) && (int'(gnt_q) == i)) begin
                pop[i] = 1'b1;
            end
            if (state_q == DELIVER) begin
                if (dest_is_bcast) begin
                    push[i] = (int'(gnt_q) != i);
                end else if (dest_is_uni) begin
                    push[i] = (int'(dest) == i);
                end
            end
        end
    end

    assign D_push   = {drvrs{data_reg}};
    assign busy     = (state_q != IDLE);
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_prll_bs_rr_rbtr.sv
// Directed bench for prll_bs_rr_rbtr at default parameters (6 x 32b, 8b ID).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_prll_bs_rr_rbtr;

    logic           clk;
    logic           reset;
    logic [5:0]     pndng;
    logic [191:0]   d_pop;
    logic [5:0]     pop;
    logic [5:0]     push;
    logic [191:0]   d_push;
    logic           busy;
    logic [15:0]    drop_cnt;

    int checks = 0;
    int errors = 0;

    prll_bs_rr_rbtr dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (d_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (d_push),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] oh(input int i);
        logic [5:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic do_reset();
        pndng = '0;
        d_pop = '0;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // One full transfer from an idle DUT: returns the strobes seen in the
    // pop cycle and in the delivery cycle, and the delivered slice 0.
    task automatic do_xfer(input int drv, input logic [31:0] word,
                           output logic [5:0] pop_seen, output logic [5:0] push_seen,
                           output logic [31:0] dat_seen);
        d_pop[drv*32 +: 32] = word;
        pndng = oh(drv);
        @(negedge clk);
        pop_seen = pop;
        pndng = '0;
        @(negedge clk);
        push_seen = push;
        dat_seen  = d_push[31:0];
        @(negedge clk);
    endtask

    task automatic test_reset();
        pndng = '0;
        d_pop = '0;
        reset = 1'b0;
        #3;
        checks++;
        if ({pop, push, busy} !== 13'd0) begin
            errors++;
            $display("FAIL reset_strobes got pop=%b push=%b busy=%b want all 0", pop, push, busy);
        end
        checks++;
        if (drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_drop_cnt got %h want 0000", drop_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy got %b want 0", busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        d_pop[31:0] = 32'h0300ABCD;
        pndng = 6'b000001;
        @(negedge clk);
        checks++;
        if (pop !== 6'b000001 || push !== 6'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_pop got pop=%b push=%b busy=%b want 000001 000000 1", pop, push, busy);
        end
        pndng = '0;
        @(negedge clk);
        checks++;
        if (push !== 6'b001000 || pop !== 6'b0) begin
            errors++;
            $display("FAIL single_push got push=%b pop=%b want 001000 000000", push, pop);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (d_push[i*32 +: 32] !== 32'h0300ABCD) begin
                errors++;
                $display("FAIL single_dpush slice %0d got %h want 0300abcd", i, d_push[i*32 +: 32]);
            end
        end
        @(negedge clk);
        checks++;
        if (push !== 6'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_after got push=%b busy=%b want 000000 0", push, busy);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 6; i++) d_pop[i*32 +: 32] = {8'(i), 24'(i)};
        pndng = 6'b111111;
        for (int g = 0; g < 7; g++) begin
            @(negedge clk);
            checks++;
            if (pop !== oh(g % 6)) begin
                errors++;
                $display("FAIL rr_pop grant %0d got %b want %b", g, pop, oh(g % 6));
            end
            @(negedge clk);
            checks++;
            if (push !== oh(g % 6) || pop !== 6'b0) begin
                errors++;
                $display("FAIL rr_push grant %0d got push=%b pop=%b want %b 000000", g, push, pop, oh(g % 6));
            end
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || pop !== 6'b0) begin
                errors++;
                $display("FAIL rr_idle grant %0d got busy=%b pop=%b want 0 000000", g, busy, pop);
            end
            if (g == 6) pndng = '0;
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_broadcast();
        logic [5:0]  ps, qs;
        logic [31:0] ds;
        do_reset();
        do_xfer(2, 32'hFF123456, ps, qs, ds);
        checks++;
        if (ps !== 6'b000100) begin
            errors++;
            $display("FAIL bcast_pop got %b want 000100", ps);
        end
        checks++;
        if (qs !== 6'b111011 || ds !== 32'hFF123456) begin
            errors++;
            $display("FAIL bcast_push got %b data %h want 111011 ff123456", qs, ds);
        end
        checks++;
        if (push !== 6'b0 || drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL bcast_after got push=%b drop=%h want 000000 0000", push, drop_cnt);
        end
    endtask

    task automatic test_drop();
        logic [5:0]  ps, qs;
        logic [31:0] ds;
        do_reset();
        do_xfer(1, 32'h09000001, ps, qs, ds);
        checks++;
        if (ps !== 6'b000010 || qs !== 6'b0 || drop_cnt !== 16'd1) begin
            errors++;
            $display("FAIL drop_09 got pop=%b push=%b drop=%h want 000010 000000 0001", ps, qs, drop_cnt);
        end
        do_xfer(5, 32'h06000005, ps, qs, ds);
        checks++;
        if (qs !== 6'b0 || drop_cnt !== 16'd2) begin
            errors++;
            $display("FAIL drop_06 got push=%b drop=%h want 000000 0002", qs, drop_cnt);
        end
        do_xfer(0, 32'h05000000, ps, qs, ds);
        checks++;
        if (qs !== 6'b100000 || drop_cnt !== 16'd2) begin
            errors++;
            $display("FAIL drop_valid05 got push=%b drop=%h want 100000 0002", qs, drop_cnt);
        end
        // Jump the counter near saturation rather than running 65k drops.
        force dut.drop_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.drop_cnt_q;
        @(negedge clk);
        checks++;
        if (drop_cnt !== 16'hFFFE) begin
            errors++;
            $display("FAIL drop_preload got %h want fffe", drop_cnt);
        end
        do_xfer(3, 32'h09000003, ps, qs, ds);
        checks++;
        if (drop_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL drop_reach_max got %h want ffff", drop_cnt);
        end
        do_xfer(4, 32'h0A000004, ps, qs, ds);
        checks++;
        if (drop_cnt !== 16'hFFFF || qs !== 6'b0) begin
            errors++;
            $display("FAIL drop_saturate got %h push=%b want ffff 000000", drop_cnt, qs);
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0]  ps, qs;
        logic [31:0] ds;
        do_reset();
        do_xfer(3, 32'h00000003, ps, qs, ds);
        checks++;
        if (qs !== 6'b000001) begin
            errors++;
            $display("FAIL rstmid_first got push=%b want 000001", qs);
        end
        d_pop[4*32 +: 32] = 32'h00000004;
        pndng = 6'b010000;
        @(negedge clk);
        checks++;
        if (pop !== 6'b010000) begin
            errors++;
            $display("FAIL rstmid_pop got %b want 010000", pop);
        end
        pndng = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (push !== 6'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_abort got push=%b busy=%b want 000000 0", push, busy);
        end
        @(negedge clk);
        checks++;
        if (push !== 6'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_held got push=%b busy=%b want 000000 0", push, busy);
        end
        reset = 1'b1;
        pndng = 6'b111111;
        @(negedge clk);
        checks++;
        if (pop !== 6'b000001) begin
            errors++;
            $display("FAIL rstmid_next_grant got %b want 000001", pop);
        end
        pndng = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_loopback_random();
        logic [5:0]  ps, qs;
        logic [31:0] ds;
        logic [5:0]  prev_pop;
        logic [7:0]  dst;
        do_reset();
        do_xfer(4, 32'h0400BEEF, ps, qs, ds);
        checks++;
        if (ps !== 6'b010000 || qs !== 6'b010000 || ds !== 32'h0400BEEF) begin
            errors++;
            $display("FAIL loopback got pop=%b push=%b data=%h want 010000 010000 0400beef", ps, qs, ds);
        end
        prev_pop = '0;
        for (int c = 0; c < 200; c++) begin
            pndng = 6'($urandom_range(0, 63));
            for (int i = 0; i < 6; i++) begin
                dst = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 9));
                d_pop[i*32 +: 32] = {dst, 24'($urandom)};
            end
            @(negedge clk);
            checks++;
            if ($countones(pop) > 1 || (|pop && |push) || (|push && prev_pop == 6'b0)) begin
                errors++;
                $display("FAIL rand_strobes cycle %0d got pop=%b push=%b prev_pop=%b", c, pop, push, prev_pop);
            end
            prev_pop = pop;
        end
        pndng = '0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        pndng = '0;
        d_pop = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_broadcast();
        test_drop();
        test_reset_mid();
        test_loopback_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
